eight_rainbow_light: RTL and testbench

//   Eight-LED "rainbow" pattern generator for a board-level LED bank.

---
 rtl/eight_rainbow_light.sv | 54 +++++
 tb/tb_eight_rainbow_light.sv | 117 +++++++++++
 2 files changed

// File: rtl/eight_rainbow_light.sv
// eight_rainbow_light: eight-LED rainbow pattern generator with prescaler and two selectable patterns
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active low (0 = in reset)
//   control : pattern select, 0 = fill/drain, 1 = walking light
//   dout    : registered LED bank, bit0 = rightmost LED, 1 = lit
module eight_rainbow_light #(
   parameter int DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       control,
   output logic [7:0] dout
);
   localparam int PW = $clog2(DIV) + 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);
   logic [7:0]    dout_d;
   logic [3:0]    step_q, step_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          mode_q, mode_d;
   // Upper half of each pattern reuses the low index bits: drain shifts ones out, walk-right shifts down.
   function automatic logic [7:0] pat(input logic m, input logic [3:0] i);
      return m ? (i[3] ? 8'h80 >> i[2:0] : 8'h01 << i[2:0])
               : (i[3] ? 8'hFF << ({1'b0, i[2:0]} + 4'd1) : 8'hFF >> (3'd7 - i[2:0]));
   endfunction
   always_comb begin
      mode_d = mode_q;
      dout_d = dout;
      step_d = step_q;
      pcnt_d = pcnt_q + PW'(1);
      if (control != mode_q) begin
         mode_d = control;
         dout_d = pat(control, 4'd0);
         step_d = 4'd1;
         pcnt_d = '0;
      end else if (pcnt_q == LAST) begin
         dout_d = pat(mode_q, step_q);
         step_d = step_q + 4'd1;
         pcnt_d = '0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout   <= 8'h00;
         step_q <= 4'd0;
         pcnt_q <= '0;
         mode_q <= 1'b0;
      end else begin
         dout   <= dout_d;
         step_q <= step_d;
         pcnt_q <= pcnt_d;
         mode_q <= mode_d;
      end
   end
endmodule

// File: tb/tb_eight_rainbow_light.sv
// tb_eight_rainbow_light: directed self-checking bench for eight_rainbow_light at DIV=1 and DIV=4
module tb_eight_rainbow_light;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       control = 1'b0;
   logic [7:0] dout1, dout4;
   int         pass_cnt = 0;
   int         total = 0;
   localparam logic [7:0] T0 [0:15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                        8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
   localparam logic [7:0] T1 [0:15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                        8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
   localparam logic [7:0] FD [0:16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                        8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
   localparam logic [7:0] WK [0:16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                        8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01};
   localparam logic [7:0] D4 [0:11] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01,
                                        8'h03, 8'h03, 8'h03, 8'h03, 8'h07};
   always #5 clk = ~clk;
   eight_rainbow_light #(.DIV(1)) dut1 (.clk(clk), .rst(rst), .control(control), .dout(dout1));
   eight_rainbow_light #(.DIV(4)) dut4 (.clk(clk), .rst(rst), .control(control), .dout(dout4));
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
   endtask
   // Model: n counts edges since reset release or since the last mode change.
   // After a mode change the pattern index is n/DIV; after reset the first tick lands at n=DIV.
   logic mmode = 1'b0;
   bit   fresh = 1'b1;
   int   n = 0;
   function automatic logic [7:0] expv(input int div);
      if (fresh) return (n < div) ? 8'h00 : (mmode ? T1[(n/div - 1) % 16] : T0[(n/div - 1) % 16]);
      return mmode ? T1[(n/div) % 16] : T0[(n/div) % 16];
   endfunction
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mmode = 1'b0;
         fresh = 1'b1;
         n = 0;
      end else if (control !== mmode) begin
         mmode = control;
         fresh = 1'b0;
         n = 0;
      end else n++;
   end
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_div1", dout1, 8'h00);
         chk("rst_div4", dout4, 8'h00);
      end else begin
         chk("model_div1", dout1, expv(1));
         chk("model_div4", dout4, expv(4));
      end
   end
   initial begin
      #2 rst = 1'b0;
      @(negedge clk);
      chk("reset_hold", dout1, 8'h00);
      #1 rst = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         chk("fill_drain", dout1, FD[i]);
         if (i < 12) chk("div4_seq", dout4, D4[i]);
      end
      repeat (4) @(negedge clk);
      chk("step5", dout1, 8'h1F);
      #1 control = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         chk("walk", dout1, WK[i]);
      end
      #1 control = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("back_to_0", dout1, FD[i]);
      end
      #2 rst = 1'b0;
      #1;
      chk("async_div1", dout1, 8'h00);
      chk("async_div4", dout4, 8'h00);
      @(negedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("restart", dout1, FD[i]);
      end
      #1 begin
         rst = 1'b0;
         control = 1'b1;
      end
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("restart_m1", dout1, 8'h01);
      @(negedge clk);
      chk("restart_m1_next", dout1, 8'h02);
      #1 control = 1'b0;
      @(negedge clk);
      chk("m0_again", dout1, 8'h01);
      repeat (9) @(negedge clk);
      chk("step10", dout1, 8'hFC);
      #1 control = 1'b1;
      @(negedge clk);
      chk("glitch_a", dout1, 8'h01);
      #1 control = 1'b0;
      @(negedge clk);
      chk("glitch_b", dout1, 8'h01);
      @(negedge clk);
      chk("glitch_c", dout1, 8'h03);
      @(negedge clk);
      chk("glitch_d", dout1, 8'h07);
      repeat (70) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
